// File: rtl/gf2m_pkg.sv
// Shared constants and types for the GF(2^m) field-arithmetic datapath.
// Default field is NIST B-163: f = x^163 + x^7 + x^6 + x^3 + 1.
package gf2m_pkg;

    localparam int M_DEFAULT = 163;

    // bits 163, 7, 6, 3, 0
    localparam logic [M_DEFAULT:0] POLY_B163 = (164'd1 << 163) | 164'h0C9;

    typedef logic [M_DEFAULT-1:0] fe_t;
    typedef logic [M_DEFAULT:0]   fe_wide_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/gf2m_binary_inverter_if.sv
// Start/done handshake and operand/result bus of the field inverter.
// The master drives start and a; the slave (the inverter) returns busy, done, err and y.
interface gf2m_binary_inverter_if #(
    parameter int M = gf2m_pkg::M_DEFAULT
);
    logic         start;
    logic [M-1:0] a;
    logic         busy;
    logic         done;
    logic         err;
    logic [M-1:0] y;

    modport master (output start, a, input busy, done, err, y);
    modport slave  (input start, a, output busy, done, err, y);

endinterface

// File: rtl/gf2m_halve.sv
// Division by x modulo f for an M-bit field element: odd inputs get f added first,
// and bit M of that sum lands in bit M-1 of the result.
module gf2m_halve #(
    parameter int         M    = gf2m_pkg::M_DEFAULT,
    parameter logic [M:0] POLY = gf2m_pkg::POLY_B163[M:0]
) (
    input  logic [M-1:0] i_g,
    output logic [M-1:0] o_h
);

    logic [M:0] w_sum;

    assign w_sum = {1'b0, i_g} ^ POLY;
    assign o_h   = i_g[0] ? w_sum[M:1] : {1'b0, i_g[M-1:1]};

endmodule

// File: rtl/gf2m_binary_inverter.sv
// Binary extended-Euclid inverter over GF(2^M): y = a^-1 mod f, one reduction step per clock.
// state | meaning
// IDLE  | waiting for start; a==0 answers immediately with err
// RUN   | reducing u/v toward 1 while tracking g1/g2 so that g*a == u/v (mod f)
module gf2m_binary_inverter
    import gf2m_pkg::*;
#(
    parameter int         M    = M_DEFAULT,
    parameter logic [M:0] POLY = POLY_B163[M:0]
) (
    input  logic                  clk,
    input  logic                  rst,
    gf2m_binary_inverter_if.slave io_inv
);

    localparam logic [M:0]   ONE_W = (M+1)'(1);
    localparam logic [M-1:0] ONE_F = M'(1);

    state_t       r_state;
    logic [M:0]   r_u;
    logic [M:0]   r_v;
    logic [M-1:0] r_g1;
    logic [M-1:0] r_g2;
    logic [M-1:0] r_y;
    logic         r_done;
    logic         r_err;

    state_t       w_state_nxt;
    logic [M:0]   w_u_nxt;
    logic [M:0]   w_v_nxt;
    logic [M-1:0] w_g1_nxt;
    logic [M-1:0] w_g2_nxt;
    logic [M-1:0] w_y_nxt;
    logic         w_done_nxt;
    logic         w_err_nxt;

    logic [M-1:0] w_g1_half;
    logic [M-1:0] w_g2_half;

    gf2m_halve #(.M(M), .POLY(POLY)) u_halve_g1 (
        .i_g (r_g1),
        .o_h (w_g1_half)
    );

    gf2m_halve #(.M(M), .POLY(POLY)) u_halve_g2 (
        .i_g (r_g2),
        .o_h (w_g2_half)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_u     <= '0;
            r_v     <= '0;
            r_g1    <= '0;
            r_g2    <= '0;
            r_y     <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_u     <= w_u_nxt;
            r_v     <= w_v_nxt;
            r_g1    <= w_g1_nxt;
            r_g2    <= w_g2_nxt;
            r_y     <= w_y_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_u_nxt     = r_u;
        w_v_nxt     = r_v;
        w_g1_nxt    = r_g1;
        w_g2_nxt    = r_g2;
        w_y_nxt     = r_y;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (io_inv.start) begin
                    if (io_inv.a == '0) begin
                        w_y_nxt    = '0;
                        w_err_nxt  = 1'b1;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_u_nxt     = {1'b0, io_inv.a};
                        w_v_nxt     = POLY;
                        w_g1_nxt    = ONE_F;
                        w_g2_nxt    = '0;
                        w_state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (r_u == ONE_W) begin
                    w_y_nxt     = r_g1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_v == ONE_W) begin
                    w_y_nxt     = r_g2;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (!r_u[0]) begin
                    w_u_nxt  = r_u >> 1;
                    w_g1_nxt = w_g1_half;
                end else if (!r_v[0]) begin
                    w_v_nxt  = r_v >> 1;
                    w_g2_nxt = w_g2_half;
                end else if (r_u > r_v) begin
                    // integer compare stands in for degree compare; equal degrees still shrink
                    w_u_nxt  = r_u ^ r_v;
                    w_g1_nxt = r_g1 ^ r_g2;
                end else begin
                    w_v_nxt  = r_v ^ r_u;
                    w_g2_nxt = r_g2 ^ r_g1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign io_inv.busy = (r_state == RUN);
    assign io_inv.done = r_done;
    assign io_inv.err  = r_err;
    assign io_inv.y    = r_y;

endmodule
